seg_scan4: RTL and testbench
============================

# seg_scan4

Four-digit multiplexed 7-segment scan driver that displays the outputs of up to four cascaded 4-bit up/down counter stages. It accepts the counter nibbles and the carry/borrow (CO) of the most significant stage, then drives a common-anode digit-select bus and active-high segment lines. It also provides a sticky overflow flag and optional leading-zero blanking. It sits directly downstream of the counter chain and feeds the board display pins.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- CLK  in  1  system clock; all state changes on the rising edge.
- MR  in  1  reset, synchronous, active-high.
- D  in  16  counter values, hex; D[3:0] is digit 0 (least significant) and D[15:12] is digit 3.
- CO  in  1  carry/borrow level from the top counter stage.
- CLR  in  1  clears OVF; synchronous, active-high.
- BLANK_EN  in  1  leading-zero blanking enable.
- AN  out  4  digit enables, one-hot active-low; AN[i] selects digit i.
- SEG  out  7  segments, active-high; SEG[0]=a … SEG[6]=g.
- DP  out  1  decimal point, active-high.
- OVF  out  1  sticky overflow flag.

## Operation
- **Prescaler:** `cnt` counts 0..DIV-1 and wraps. `tick` = (cnt == DIV-1).
- **Digit index:** 2-bit `idx` advances 0→1→2→3→0 on each tick.
- **Frame snapshot:** 16-bit `shadow` loads D on the tick where idx goes 3→0. It holds at all other times, so the displayed value is coherent across a frame.
- **Decode:** every cycle, SEG is loaded from the full hex decode of shadow nibble idx (g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Digit select:** AN is loaded with the one-hot-low code for idx.
- **Leading-zero blanking:** when BLANK_EN=1, digit k (k = 3, 2, 1) is blanked if shadow digits k..3 are all zero. A blanked digit drives AN=1111 and SEG=0000000 for its slot. Digit 0 is never blanked. BLANK_EN is sampled every cycle; it is not snapshotted.
- **Overflow:** `co_d` is a register holding CO delayed one cycle.
  - OVF sets on CO & ~co_d (rising edge).
  - OVF clears on CLR.
  - If the set and clear conditions occur in the same cycle, set wins.
  - A level held high on CO produces exactly one set.
- **Decimal point:** DP = OVF during digit 0 slots and 0 in all other slots; registered together with SEG.
- **Reset (MR=1):**
  - Internal: cnt=0, idx=0, shadow=0, co_d=0.
  - Outputs: OVF=0, AN=1111, SEG=0000000, DP=0.
  - MR overrides CLR, CO and the tick.
  - MR asserted mid-frame aborts the frame, and the scan restarts at digit 0.

## Timing
- AN, SEG and DP are registered with 1-cycle latency from idx/shadow.
  - The first cycle after MR releases shows digit 0 of shadow=0: AN=1110, SEG=3F.
- Digit slot = DIV cycles; frame = 4·DIV cycles.
- A change on D becomes visible at the first frame boundary after it.
  - Worst case: 4·DIV + 1 cycles.
- OVF asserts 1 cycle after the CO rising edge is sampled.
  - DP reflects OVF within 1 cycle while in a digit 0 slot.
- CLR takes effect on the next edge (OVF=0 the cycle after).
- No combinational paths from inputs to outputs.

## Test plan
All scenarios use DIV=4.
- **Reset:** MR=1 for 3 cycles with D=FFFF and CO toggling → AN=1111, SEG=00, DP=0, OVF=0 throughout. The cycle after release: AN=1110, SEG=3F.
- **Scan order:** D=12A0, BLANK_EN=0. After the first frame boundary:
  - AN cycles 1110 / 1101 / 1011 / 0111, each held for exactly 4 cycles.
  - SEG = 3F / 77 / 5B / 06 respectively; the pattern repeats every 16 cycles.
- **Blanking:**
  - BLANK_EN=1, D=0050 → digit 3 and 2 slots show AN=1111, SEG=00; digit 1 shows 6D; digit 0 shows 3F.
  - D=0000 → only digit 0 is lit, with 3F.
  - D=0800 → digit 1 is not blanked (shows 3F).
- **Snapshot:** D=1111 is displayed. Switch D to 2222 during a digit-1 slot → the remainder of the frame still shows 06. The next frame shows 5B on all digits.
- **Overflow:**
  - 1-cycle CO pulse → OVF=1 the following cycle; DP=1 only in digit 0 slots.
  - CO held high for 10 cycles after CLR → OVF sets once and stays 0 after a further CLR while CO remains high.
  - CLR coincident with a new CO rising edge → OVF=1.
- **Mid-frame reset:** MR pulsed during a digit-2 slot → the next cycle has all outputs at reset values. After release, the scan restarts at AN=1110 with shadow=0.

Source files
------------

// File: rtl/seg_scan4.sv
// Four-digit multiplexed 7-segment scan driver with per-frame input snapshot,
// optional leading-zero blanking and a sticky carry/borrow overflow flag.
module seg_scan4 #(
  parameter int DIV = 50000
) (
  input  logic        CLK,
  input  logic        MR,
  input  logic [15:0] D,
  input  logic        CO,
  input  logic        CLR,
  input  logic        BLANK_EN,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        OVF
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic          co_d;

  logic          tick;
  logic          frame_end;
  logic          co_rise;
  logic [3:0]    nib;
  logic          lead_zero;
  logic          blank;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic          ovf_next;

  // Full hex decode, segment order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One-hot active-low digit enable for a slot index.
  function automatic logic [3:0] idx_to_an(input logic [1:0] i);
    logic [3:0] a;
    case (i)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      2'd3:    a = 4'b0111;
      default: a = 4'b1111;
    endcase
    return a;
  endfunction

  // Prescaler wrap, frame boundary and CO edge detection.
  always_comb begin
    tick      = (cnt == CNT_MAX);
    frame_end = tick && (idx == 2'd3);
    co_rise   = CO && !co_d;
  end

  // Select the current nibble and decide whether it is a leading zero.
  always_comb begin
    nib       = 4'h0;
    lead_zero = 1'b0;
    case (idx)
      2'd0: begin
        nib       = shadow[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        nib       = shadow[7:4];
        lead_zero = (shadow[15:4] == 12'h000);
      end
      2'd2: begin
        nib       = shadow[11:8];
        lead_zero = (shadow[15:8] == 8'h00);
      end
      2'd3: begin
        nib       = shadow[15:12];
        lead_zero = (shadow[15:12] == 4'h0);
      end
      default: begin
        nib       = 4'h0;
        lead_zero = 1'b0;
      end
    endcase
  end

  // Next-state values for the registered display outputs and flag.
  always_comb begin
    blank    = BLANK_EN && lead_zero;
    an_next  = 4'b1111;
    seg_next = 7'h00;
    if (blank) begin
      an_next  = 4'b1111;
      seg_next = 7'h00;
    end else begin
      an_next  = idx_to_an(idx);
      seg_next = hex_to_seg(nib);
    end
    if (idx == 2'd0) begin
      dp_next = OVF;
    end else begin
      dp_next = 1'b0;
    end
    // A new CO edge wins over a simultaneous clear.
    if (co_rise) begin
      ovf_next = 1'b1;
    end else if (CLR) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = OVF;
    end
  end

  // Scan state, snapshot, overflow flag and registered outputs.
  always_ff @(posedge CLK) begin
    if (MR) begin
      cnt    <= '0;
      idx    <= 2'd0;
      shadow <= 16'h0000;
      co_d   <= 1'b0;
      OVF    <= 1'b0;
      AN     <= 4'b1111;
      SEG    <= 7'h00;
      DP     <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      if (frame_end) begin
        shadow <= D;
      end
      co_d <= CO;
      OVF  <= ovf_next;
      AN   <= an_next;
      SEG  <= seg_next;
      DP   <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_scan4.sv
// Self-checking bench for seg_scan4: vector table, directed corner sequences
// and randomized traffic against a slot/frame arithmetic reference model.
module tb_seg_scan4;

  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        MR = 1'b1;
  logic [15:0] D = 16'h0000;
  logic        CO = 1'b0;
  logic        CLR = 1'b0;
  logic        BLANK_EN = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        OVF;

  int n_cmp = 0;
  int n_fail = 0;

  seg_scan4 #(.DIV(DIV)) dut (
    .CLK(CLK), .MR(MR), .D(D), .CO(CO), .CLR(CLR), .BLANK_EN(BLANK_EN),
    .AN(AN), .SEG(SEG), .DP(DP), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: time since reset decides slot and frame boundaries.
  int          m = 0;
  logic [15:0] shadow_m = 16'h0000;
  logic        prev_co = 1'b0;
  logic        ovf_m = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h00;
  logic        e_dp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int slot;
    logic [3:0] nv;
    logic lit;
    @(posedge CLK);
    if (MR) begin
      m = 0; shadow_m = 16'h0000; prev_co = 1'b0; ovf_m = 1'b0;
      e_an = 4'hF; e_seg = 7'h00; e_dp = 1'b0;
    end else begin
      slot  = (m / DIV) % 4;
      nv    = shadow_m[slot*4 +: 4];
      lit   = !(BLANK_EN && slot != 0 && (shadow_m >> (4*slot)) == 16'h0000);
      e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
      e_seg = lit ? hex7[nv] : 7'h00;
      e_dp  = (slot == 0) ? ovf_m : 1'b0;
      if (CO && !prev_co) ovf_m = 1'b1;
      else if (CLR) ovf_m = 1'b0;
      prev_co = CO;
      if (m % (4*DIV) == 4*DIV - 1) shadow_m = D;
      m++;
    end
    #1;
    chk("model_an", 32'(AN), 32'(e_an));
    chk("model_seg", 32'(SEG), 32'(e_seg));
    chk("model_dp", 32'(DP), 32'(e_dp));
    chk("model_ovf", 32'(OVF), 32'(ovf_m));
  endtask

  task automatic do_reset();
    MR = 1'b1;
    step();
    MR = 1'b0;
  endtask

  typedef struct {
    logic [15:0] d;
    logic        blank;
    logic [15:0] an;
    logic [27:0] seg;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit found;
    vecs[0] = '{16'h12A0, 1'b0, 16'h7BDE, {7'h06, 7'h5B, 7'h77, 7'h3F}};
    vecs[1] = '{16'h0050, 1'b1, 16'hFFDE, {7'h00, 7'h00, 7'h6D, 7'h3F}};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFFE, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{16'h0800, 1'b1, 16'hFBDE, {7'h00, 7'h7F, 7'h3F, 7'h3F}};
    vecs[4] = '{16'hFFFF, 1'b0, 16'h7BDE, {7'h71, 7'h71, 7'h71, 7'h71}};
    vecs[5] = '{16'h89BC, 1'b1, 16'h7BDE, {7'h7F, 7'h6F, 7'h7C, 7'h39}};
    vecs[6] = '{16'h3D7E, 1'b0, 16'h7BDE, {7'h4F, 7'h5E, 7'h07, 7'h79}};
    vecs[7] = '{16'h0004, 1'b0, 16'h7BDE, {7'h3F, 7'h3F, 7'h3F, 7'h66}};

    // Reset held with busy inputs.
    MR = 1'b1; D = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      CO = ~CO;
      step();
      chk("reset_an", 32'(AN), 32'hF);
      chk("reset_seg", 32'(SEG), 32'h0);
      chk("reset_dp", 32'(DP), 32'h0);
      chk("reset_ovf", 32'(OVF), 32'h0);
    end
    MR = 1'b0; CO = 1'b0;
    step();
    chk("release_an", 32'(AN), 32'hE);
    chk("release_seg", 32'(SEG), 32'h3F);

    // Static displays from the vector table, two frames each.
    for (int v = 0; v < 8; v++) begin
      D = vecs[v].d; BLANK_EN = vecs[v].blank;
      do_reset();
      for (int i = 0; i < 16; i++) step();
      for (int f = 0; f < 2; f++) begin
        for (int k = 0; k < 4; k++) begin
          step(); step();
          chk($sformatf("vec%0d_an%0d", v, k), 32'(AN), 32'(vecs[v].an[4*k +: 4]));
          chk($sformatf("vec%0d_seg%0d", v, k), 32'(SEG), 32'(vecs[v].seg[7*k +: 7]));
          step(); step();
        end
      end
    end

    // Snapshot: D changes during a digit-1 slot; frame stays coherent.
    BLANK_EN = 1'b0; D = 16'h1111;
    do_reset();
    for (int i = 0; i < 22; i++) step();
    chk("snap_slot1", 32'(AN), 32'hD);
    D = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("snap_old", 32'(SEG), 32'h06);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      chk("snap_new", 32'(SEG), 32'h5B);
    end

    // Overflow: single CO pulse, then DP only in digit 0 slots.
    do_reset();
    step();
    CO = 1'b1;
    step();
    chk("ovf_pulse", 32'(OVF), 32'h1);
    CO = 1'b0;
    step(); step();
    for (int i = 0; i < 16; i++) begin
      step();
      chk("dp_slot", 32'(DP), 32'(AN == 4'b1110));
    end
    // CO held high: one set only.
    CLR = 1'b1; step(); CLR = 1'b0;
    chk("clr_ovf", 32'(OVF), 32'h0);
    CO = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("co_held_set", 32'(OVF), 32'h1);
    end
    CLR = 1'b1; step(); CLR = 1'b0;
    chk("co_held_clr", 32'(OVF), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("co_held_stay0", 32'(OVF), 32'h0);
    end
    CO = 1'b0; step();
    CO = 1'b1; CLR = 1'b1; step();
    chk("set_beats_clr", 32'(OVF), 32'h1);
    CO = 1'b0; CLR = 1'b0; step();

    // Mid-frame reset during a digit-2 slot.
    D = 16'h4321;
    for (int i = 0; i < 17; i++) step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (AN == 4'b1011) found = 1'b1;
    end
    chk("find_digit2", 32'(found), 32'h1);
    MR = 1'b1; step();
    chk("midrst_an", 32'(AN), 32'hF);
    chk("midrst_seg", 32'(SEG), 32'h0);
    chk("midrst_dp", 32'(DP), 32'h0);
    chk("midrst_ovf", 32'(OVF), 32'h0);
    MR = 1'b0; step();
    chk("midrst_restart_an", 32'(AN), 32'hE);
    chk("midrst_restart_seg", 32'(SEG), 32'h3F);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < 4; k++)
          D[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 99) == 0) BLANK_EN = ~BLANK_EN;
      CO  = ($urandom_range(0, 7) == 0);
      CLR = ($urandom_range(0, 15) == 0);
      MR  = ($urandom_range(0, 299) == 0);
      step();
    end
    MR = 1'b0; CO = 1'b0; CLR = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
